// File: rtl/mmio_id_tracker.sv
// rtl/mmio_id_tracker.sv - MMIO read/write transaction ID tracker (optional orphan detect: MMIO_ID_TRACKER_ERR_EN)

module mmio_id_fifo #(
    parameter int ID_WIDTH = 16,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [ID_WIDTH-1:0]        push_id,
    input  logic                       pop,
    output logic [ID_WIDTH-1:0]        head_id,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ID_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       cnt;
    logic                empty;
    logic                do_push;
    logic                do_pop;

    // Full/empty come only from the registered count, so a pop never frees a slot for a same-cycle push.
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = cnt;

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // ID storage; contents need no reset because the count masks stale entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // Head is read straight from storage; an empty FIFO presents zero.
    assign head_id = empty ? '0 : mem[rd_ptr];

endmodule

module mmio_id_tracker #(
    parameter int ID_WIDTH = 16,
    parameter int DEPTH    = 4
) (
    input  logic                       kcd_clk,
    input  logic                       kcd_reset,

    input  logic                       s_arvalid,
    input  logic [ID_WIDTH-1:0]        s_arid,
    output logic                       s_arready,
    output logic                       m_arvalid,
    input  logic                       m_arready,
    input  logic                       m_rvalid,
    input  logic                       s_rready,
    output logic [ID_WIDTH-1:0]        s_rid,

    input  logic                       s_awvalid,
    input  logic [ID_WIDTH-1:0]        s_awid,
    output logic                       s_awready,
    output logic                       m_awvalid,
    input  logic                       m_awready,
    input  logic                       m_bvalid,
    input  logic                       s_bready,
    output logic [ID_WIDTH-1:0]        s_bid,

    output logic [$clog2(DEPTH+1)-1:0] rd_count,
    output logic [$clog2(DEPTH+1)-1:0] wr_count,
    output logic                       id_err
);

    logic rd_full;
    logic wr_full;
    logic rd_push;
    logic wr_push;
    logic rd_pop;
    logic wr_pop;

    // Address channels pass through only while there is room to remember the ID; held closed in reset.
    assign s_arready = ~kcd_reset & m_arready & ~rd_full;
    assign m_arvalid = ~kcd_reset & s_arvalid & ~rd_full;
    assign s_awready = ~kcd_reset & m_awready & ~wr_full;
    assign m_awvalid = ~kcd_reset & s_awvalid & ~wr_full;

    assign rd_push = s_arvalid & s_arready;
    assign wr_push = s_awvalid & s_awready;
    assign rd_pop  = m_rvalid & s_rready;
    assign wr_pop  = m_bvalid & s_bready;

    mmio_id_fifo #(
        .ID_WIDTH (ID_WIDTH),
        .DEPTH    (DEPTH)
    ) u_rd_fifo (
        .clk      (kcd_clk),
        .rst      (kcd_reset),
        .push     (rd_push),
        .push_id  (s_arid),
        .pop      (rd_pop),
        .head_id  (s_rid),
        .count    (rd_count),
        .full     (rd_full)
    );

    mmio_id_fifo #(
        .ID_WIDTH (ID_WIDTH),
        .DEPTH    (DEPTH)
    ) u_wr_fifo (
        .clk      (kcd_clk),
        .rst      (kcd_reset),
        .push     (wr_push),
        .push_id  (s_awid),
        .pop      (wr_pop),
        .head_id  (s_bid),
        .count    (wr_count),
        .full     (wr_full)
    );

`ifdef MMIO_ID_TRACKER_ERR_EN
    logic orphan;

    assign orphan = (rd_pop & (rd_count == '0)) | (wr_pop & (wr_count == '0));

    // Sticky flag for a response that arrived with no outstanding ID to match it.
    always_ff @(posedge kcd_clk or posedge kcd_reset) begin
        if (kcd_reset) begin
            id_err <= 1'b0;
        end else if (orphan) begin
            id_err <= 1'b1;
        end
    end
`else
    assign id_err = 1'b0;
`endif

endmodule

// File: doc/mmio_id_tracker.md
MMIO_ID_TRACKER -- requirements
Module: mmio_id_tracker

Interface
REQ-001 Parameter: ID_WIDTH, default 16, width of the MMIO transaction ID.
REQ-002 Parameter: DEPTH, default 4, outstanding-ID capacity per direction; power of two, >=2.
REQ-003 Port: kcd_clk  in  1  single block clock.
REQ-004 Port: kcd_reset  in  1  reset, asynchronous, active-high.
REQ-005 Port: s_arvalid  in  1  host MMIO read-address valid.
REQ-006 Port: s_arid  in  ID_WIDTH  host MMIO read ID.
REQ-007 Port: s_arready  out  1  read-address ready to host.
REQ-008 Port: m_arvalid  out  1  read-address valid to kernel slave.
REQ-009 Port: m_arready  in  1  read-address ready from kernel slave.
REQ-010 Port: m_rvalid  in  1  read-data valid from kernel slave.
REQ-011 Port: s_rready  in  1  read-data ready from host.
REQ-012 Port: s_rid  out  ID_WIDTH  ID returned with current read data.
REQ-013 Port: s_awvalid, s_awid, s_awready, m_awvalid, m_awready  -- write-address equivalents of REQ-005..009, same directions and widths.
REQ-014 Port: m_bvalid  in  1; s_bready  in  1; s_bid  out  ID_WIDTH  -- write-response equivalents of REQ-010..012.
REQ-015 Port: rd_count, wr_count  out  $clog2(DEPTH+1)  outstanding IDs per direction.
REQ-016 Port: id_err  out  1  sticky orphan-response flag.

Function
REQ-017 Two independent FIFOs, read (AR->R) and write (AW->B), DEPTH entries each, ID_WIDTH bits per entry, registered storage.
REQ-018 m_arvalid = s_arvalid & ~rd_full; s_arready = m_arready & ~rd_full; write side identical with wr_full.
REQ-019 Push read ID on s_arvalid & s_arready; no combinational path from pop to push: when full, a pop in the same cycle does not enable a push.
REQ-020 Pop read ID on m_rvalid & s_rready when rd_count != 0; write side pops on m_bvalid & s_bready.
REQ-021 s_rid/s_bid = FIFO head, combinational from storage, zero latency; 0 when FIFO empty.
REQ-022 Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
REQ-023 Push onto empty FIFO: s_rid shows new ID from next cycle; same-cycle bypass not provided.
REQ-024 Pointers $clog2(DEPTH) bits, wrap modulo DEPTH; count saturates at neither bound because push/pop are gated.
REQ-025 Responses return in request order (AXI-lite); no ID reordering.
REQ-026 Pop with FIFO empty: no pointer or count change.

Reset
REQ-027 kcd_reset asserted: pointers, counts, id_err cleared immediately; s_arready, s_awready, m_arvalid, m_awvalid = 0; s_rid, s_bid = 0.
REQ-028 Reset mid-transaction: all outstanding IDs discarded; first cycle after deassertion both FIFOs empty and accepting.

Configuration
REQ-029 Macro MMIO_ID_TRACKER_ERR_EN defined: id_err sets on any R or B handshake with corresponding FIFO empty, holds until reset.
REQ-030 Macro undefined: id_err tied to 0, no detection logic; REQ-026 behaviour unchanged.

Verification
REQ-031 Reset, AR id=0x0012 accepted, m_rvalid&s_rready 3 cycles later -> s_rid=0x0012 at handshake, rd_count 1->0.
REQ-032 4 ARs ids 1,2,3,4 back-to-back, no R -> rd_count=4, s_arready=0 and m_arvalid=0 with s_arvalid high; R pops return 1,2,3,4 in order.
REQ-033 Full FIFO, R pop and new AR same cycle -> AR not accepted that cycle, accepted next cycle, rd_count 4->3->4.
REQ-034 Interleaved AW id=0xA and AR id=0xB, B then R -> s_bid=0xA, s_rid=0xB; read and write counts independent.
REQ-035 m_bvalid&s_bready with write FIFO empty -> wr_count stays 0; id_err=1 with MMIO_ID_TRACKER_ERR_EN, 0 without.
REQ-036 3 IDs outstanding, kcd_reset pulsed -> counts 0, id_err 0, ready low during reset; next AR id=0x7 returns 0x7.
